// File: rtl/ins_rom_arbiter_pkg.sv
// Shared constants for the instruction-ROM arbiter: bus widths, FSM encoding
// and the burst word stride.
package ins_rom_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] WORD_STRIDE = ADDR_W'(4);

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_BURST = 1'b1;

endpackage

// File: rtl/ins_rom_arbiter_if.sv
// CPU fetch, debug burst and ROM signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding SoC.
interface ins_rom_arbiter_if #(
  parameter int LEN_W = 8
);
  import ins_rom_arbiter_pkg::*;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_start;
  logic [ADDR_W-1:0] dbg_addr;
  logic [LEN_W-1:0]  dbg_len;
  logic              dbg_busy;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_done;

  logic              en_rom;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  cpu_req, cpu_addr, dbg_start, dbg_addr, dbg_len, rom_data,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_busy, dbg_rvalid, dbg_rdata, dbg_done,
    output en_rom, rom_addr
  );

  modport master (
    output cpu_req, cpu_addr, dbg_start, dbg_addr, dbg_len, rom_data,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_busy, dbg_rvalid, dbg_rdata, dbg_done,
    input  en_rom, rom_addr
  );

endinterface

// File: rtl/ins_rom_arbiter.sv
// One-access-per-cycle ROM arbiter: CPU has priority, the debug burst gets a
// beat at least every MAX_RUN+1 cycles. Read data returns one cycle after grant.
module ins_rom_arbiter
  import ins_rom_arbiter_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAX_RUN = 4
) (
  input  logic             clk,
  input  logic             rst,
  ins_rom_arbiter_if.slave bus
);

  localparam int              RUN_W   = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

  logic [0:0]        r_state;
  logic [RUN_W-1:0]  r_run_cnt;
  logic [LEN_W-1:0]  r_remain;
  logic [ADDR_W-1:0] r_dbg_ptr;

  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              r_dbg_done;

  logic              w_cpu_gnt;
  logic              w_dbg_gnt;
  logic              w_last_beat;

  // Grants are held off while reset is asserted so every output reads 0.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dbg_gnt = 1'b0;
    if (!rst) begin
      if (r_state == ARB_IDLE)
        w_cpu_gnt = bus.cpu_req;
      else if (!bus.cpu_req || r_run_cnt == RUN_MAX)
        w_dbg_gnt = 1'b1;
      else
        w_cpu_gnt = 1'b1;
    end
  end

  assign w_last_beat = (r_remain == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_run_cnt    <= '0;
      r_remain     <= '0;
      r_dbg_ptr    <= '0;
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= '0;
      r_dbg_done   <= 1'b0;
    end else begin
      r_cpu_rvalid <= w_cpu_gnt;
      r_dbg_rvalid <= w_dbg_gnt;
      r_dbg_done   <= w_dbg_gnt && w_last_beat;
      if (w_cpu_gnt) r_cpu_rdata <= bus.rom_data;
      if (w_dbg_gnt) r_dbg_rdata <= bus.rom_data;

      if (r_state == ARB_IDLE) begin
        // A zero-length start is dropped; the start cycle never issues a beat.
        if (bus.dbg_start && bus.dbg_len != '0) begin
          r_dbg_ptr <= bus.dbg_addr;
          r_remain  <= bus.dbg_len;
          r_run_cnt <= '0;
          r_state   <= ARB_BURST;
        end
      end else begin
        if (w_dbg_gnt) begin
          r_dbg_ptr <= r_dbg_ptr + WORD_STRIDE;
          r_remain  <= r_remain - LEN_W'(1);
          r_run_cnt <= '0;
          if (w_last_beat) r_state <= ARB_IDLE;
        end else if (w_cpu_gnt) begin
          r_run_cnt <= r_run_cnt + RUN_W'(1);
        end
      end
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.en_rom     = w_cpu_gnt | w_dbg_gnt;
  assign bus.rom_addr   = w_dbg_gnt ? r_dbg_ptr :
                          w_cpu_gnt ? bus.cpu_addr : '0;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.dbg_busy   = (r_state == ARB_BURST);
  assign bus.dbg_rvalid = r_dbg_rvalid;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.dbg_done   = r_dbg_done;

endmodule

// File: tb/tb_ins_rom_arbiter.sv
// Bench for ins_rom_arbiter: a queue-of-beats model checked every cycle, plus
// literal expectations on the grant/address trace of each directed scenario.
module tb_ins_rom_arbiter;

  localparam int MAX_RUN = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_rom_arbiter_if #(.LEN_W(8)) bus();

  ins_rom_arbiter #(.LEN_W(8), .MAX_RUN(MAX_RUN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign bus.rom_data = rom_f(bus.rom_addr);

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending debug beats are a queue of addresses; the burst is active
  // while it is non-empty. m_streak counts CPU wins while a beat waits.
  logic [31:0] m_q[$];
  int          m_streak;
  logic        m_cpu_rv, m_dbg_rv, m_dbg_done;
  logic [31:0] m_cpu_rd, m_dbg_rd;
  logic        chk_en = 1'b0;

  // Trace of DUT activity per cycle (0 idle, 1 CPU, 2 debug) for literal checks.
  int          glog[$];
  logic [31:0] alog[$];
  logic [3:0]  flog[$];  // {cpu_rvalid, dbg_rvalid, dbg_done, dbg_busy}
  logic [31:0] dlog[$];

  initial begin
    m_streak = 0; m_cpu_rv = 0; m_dbg_rv = 0; m_dbg_done = 0;
    m_cpu_rd = 0; m_dbg_rd = 0;
  end

  always @(negedge clk) begin
    logic        e_cpu, e_dbg, idle0;
    logic [31:0] e_addr;
    if (chk_en) begin
      idle0 = (m_q.size() == 0);
      e_cpu = 1'b0;
      e_dbg = 1'b0;
      if (!rst) begin
        if (idle0) e_cpu = bus.cpu_req;
        else if (!bus.cpu_req || m_streak == MAX_RUN) e_dbg = 1'b1;
        else e_cpu = 1'b1;
      end
      e_addr = e_dbg ? m_q[0] : (e_cpu ? bus.cpu_addr : 32'h0);

      chk("cpu_gnt",    64'(bus.cpu_gnt),    64'(e_cpu));
      chk("en_rom",     64'(bus.en_rom),     64'(e_cpu | e_dbg));
      chk("rom_addr",   64'(bus.rom_addr),   64'(e_addr));
      chk("dbg_busy",   64'(bus.dbg_busy),   64'(!idle0));
      chk("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(m_cpu_rv));
      chk("cpu_rdata",  64'(bus.cpu_rdata),  64'(m_cpu_rd));
      chk("dbg_rvalid", 64'(bus.dbg_rvalid), 64'(m_dbg_rv));
      chk("dbg_rdata",  64'(bus.dbg_rdata),  64'(m_dbg_rd));
      chk("dbg_done",   64'(bus.dbg_done),   64'(m_dbg_done));

      glog.push_back(bus.cpu_gnt ? 1 : (bus.en_rom ? 2 : 0));
      alog.push_back(bus.rom_addr);
      flog.push_back({bus.cpu_rvalid, bus.dbg_rvalid, bus.dbg_done, bus.dbg_busy});
      dlog.push_back(bus.dbg_rdata);

      if (rst) begin
        m_q.delete();
        m_streak = 0; m_cpu_rv = 0; m_dbg_rv = 0; m_dbg_done = 0;
        m_cpu_rd = 0; m_dbg_rd = 0;
      end else begin
        m_cpu_rv   = e_cpu;
        m_dbg_rv   = e_dbg;
        m_dbg_done = e_dbg && (m_q.size() == 1);
        if (e_cpu) m_cpu_rd = rom_f(e_addr);
        if (e_dbg) begin
          m_dbg_rd = rom_f(e_addr);
          void'(m_q.pop_front());
          m_streak = 0;
        end else if (e_cpu && !idle0) begin
          m_streak++;
        end
        if (idle0 && bus.dbg_start && bus.dbg_len != 0) begin
          for (int i = 0; i < int'(bus.dbg_len); i++)
            m_q.push_back(bus.dbg_addr + 32'(4 * i));
          m_streak = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [31:0] a, input logic [7:0] l);
    bus.dbg_start = 1'b1;
    bus.dbg_addr  = a;
    bus.dbg_len   = l;
  endtask

  task automatic chk_pattern(input string nm, input int base, input string pat);
    for (int i = 0; i < pat.len(); i++)
      chk(nm, 64'(glog[base + i]), (pat[i] == "C") ? 64'd1 : 64'd2);
  endtask

  initial begin
    int L, cnt, dn;
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_addr = 0;
    bus.dbg_start = 0; bus.dbg_addr = 0; bus.dbg_len = 0;
    tick();
    chk_en = 1'b1;
    chk("reset_rom_addr", 64'(bus.rom_addr), 64'h0);
    chk("reset_flags", 64'({bus.cpu_rvalid, bus.dbg_rvalid, bus.dbg_done, bus.dbg_busy}), 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // CPU only
    L = glog.size();
    bus.cpu_req = 1; bus.cpu_addr = 32'h0; tick();
    bus.cpu_addr = 32'h4; tick();
    bus.cpu_addr = 32'h8; tick();
    bus.cpu_req = 0; bus.cpu_addr = 0; tick();
    tick();
    chk_pattern("cpu_only_gnt", L, "CCC");
    chk("cpu_only_a1", 64'(alog[L + 1]), 64'h4);
    chk("cpu_only_a2", 64'(alog[L + 2]), 64'h8);
    chk("cpu_only_rv", 64'({flog[L + 1][3], flog[L + 2][3], flog[L + 3][3], flog[L + 4][3]}), 64'b1110);
    chk("cpu_only_rdata", 64'(bus.cpu_rdata), 64'hEDC3_0008);

    // Debug only
    L = glog.size();
    start(32'h100, 8'd3); tick();
    bus.dbg_start = 0; repeat (6) tick();
    chk("dbg_start_cycle_idle", 64'(glog[L]), 64'd0);
    chk("dbg_a0", 64'(alog[L + 1]), 64'h100);
    chk("dbg_a1", 64'(alog[L + 2]), 64'h104);
    chk("dbg_a2", 64'(alog[L + 3]), 64'h108);
    chk("dbg_done_cycle", 64'(flog[L + 4]), 64'b0110);
    chk("dbg_last_rdata", 64'(dlog[L + 4]), 64'hECC3_0108);
    cnt = 0; dn = 0;
    for (int i = L; i < L + 7; i++) begin
      cnt += int'(flog[i][2]);
      dn  += int'(flog[i][1]);
    end
    chk("dbg_rvalid_count", 64'(cnt), 64'd3);
    chk("dbg_done_count", 64'(dn), 64'd1);

    // Contention: CPU held high through a two-beat burst
    L = glog.size();
    start(32'h200, 8'd2); bus.cpu_req = 1; bus.cpu_addr = 32'h40; tick();
    bus.dbg_start = 0; repeat (11) tick();
    bus.cpu_req = 0; repeat (2) tick();
    chk_pattern("contention", L + 1, "CCCCDCCCCDC");
    chk("contention_a_beat0", 64'(alog[L + 5]), 64'h200);
    chk("contention_a_beat1", 64'(alog[L + 10]), 64'h204);

    // Zero-length start is ignored
    L = glog.size();
    start(32'h300, 8'd0); tick();
    bus.dbg_start = 0; repeat (3) tick();
    cnt = 0;
    for (int i = L; i < L + 4; i++) cnt += int'(glog[i] != 0) + int'(flog[i][0]);
    chk("len0_no_activity", 64'(cnt), 64'd0);

    // Start during burst does not disturb it
    L = glog.size();
    start(32'h400, 8'd3); tick();
    bus.dbg_start = 0; tick();
    start(32'h500, 8'd5); tick();
    bus.dbg_start = 0; repeat (7) tick();
    cnt = 0;
    for (int i = L; i < L + 10; i++) cnt += int'(flog[i][2]);
    chk("restart_ignored_beats", 64'(cnt), 64'd3);
    chk("restart_ignored_a2", 64'(alog[L + 3]), 64'h408);

    // Address wrap
    L = glog.size();
    start(32'hFFFF_FFFC, 8'd2); tick();
    bus.dbg_start = 0; repeat (4) tick();
    chk("wrap_a0", 64'(alog[L + 1]), 64'hFFFF_FFFC);
    chk("wrap_a1", 64'(alog[L + 2]), 64'h0);
    chk("wrap_en", 64'(glog[L + 2]), 64'd2);

    // Reset after beat 1 of 4, then a clean new burst
    L = glog.size();
    start(32'h600, 8'd4); tick();
    bus.dbg_start = 0; tick();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("rst_mid_beat1", 64'(alog[L + 1]), 64'h600);
    chk("rst_mid_flags", 64'(flog[L + 3]), 64'h0);
    chk("rst_mid_rdata", 64'(dlog[L + 3]), 64'h0);
    chk("rst_mid_gnt", 64'(glog[L + 3]), 64'd0);
    L = glog.size();
    start(32'h700, 8'd2); bus.cpu_req = 1; bus.cpu_addr = 32'h80; tick();
    bus.dbg_start = 0; repeat (10) tick();
    bus.cpu_req = 0; repeat (4) tick();
    chk_pattern("post_reset_run", L + 1, "CCCCDCCCCD");
    chk("post_reset_a", 64'(alog[L + 5]), 64'h700);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
